// File: rtl/clock_pkg.sv
// Shared widths, limits and edit-state encodings for the clock time-setting logic.
package clock_pkg;
  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN      = 2'd0;
  localparam state_t ST_SET_HOUR = 2'd1;
  localparam state_t ST_SET_MIN  = 2'd2;
endpackage

// File: rtl/wrap_counter.sv
// Loadable up/down counter over 0..MAX with wrap in both directions.
module wrap_counter #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned MAX   = 59
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      // Out-of-range live values are forced to zero rather than carried in.
      count <= (load_val > MAX_V) ? '0 : load_val;
    end else if (en && (inc != dec)) begin
      if (inc) begin
        count <= (count == MAX_V) ? '0 : count + 1'b1;
      end else begin
        count <= (count == '0) ? MAX_V : count - 1'b1;
      end
    end
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting FSM: RUN -> SET_HOUR -> SET_MIN -> RUN with load strobe and inactivity timeout.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_p,
  input  logic              up_p,
  input  logic              down_p,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  output logic [1:0]        state,
  output logic [HOUR_W-1:0] set_hour,
  output logic [MIN_W-1:0]  set_min,
  output logic              load,
  output logic              editing
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;
  logic             in_set;
  logic             press;
  logic             timed_out;
  state_t           state_nx;

  assign in_set    = (state != ST_RUN);
  assign press     = mode_p | up_p | down_p;
  assign timed_out = in_set && !press && (to_cnt == TO_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:      if (mode_p) state_nx = ST_SET_HOUR;
      ST_SET_HOUR: if (mode_p) state_nx = ST_SET_MIN;
                   else if (timed_out) state_nx = ST_RUN;
      ST_SET_MIN:  if (mode_p || timed_out) state_nx = ST_RUN;
      default:     state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RUN;
      load    <= 1'b0;
      editing <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nx;
      editing <= (state_nx != ST_RUN);
      // Only the SET_MIN mode exit commits; a timeout exit never loads.
      load    <= (state == ST_SET_MIN) && mode_p;
      to_cnt  <= (!in_set || press || timed_out) ? '0 : to_cnt + 1'b1;
    end
  end

  wrap_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == ST_RUN) && mode_p),
    .load_val (cur_hour),
    .inc      (up_p),
    .dec      (down_p),
    .en       ((state == ST_SET_HOUR) && !mode_p),
    .count    (set_hour)
  );

  wrap_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .reset    (reset),
    .load     ((state == ST_RUN) && mode_p),
    .load_val (cur_min),
    .inc      (up_p),
    .dec      (down_p),
    .en       ((state == ST_SET_MIN) && !mode_p),
    .count    (set_min)
  );
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed vector table plus hand sequences for timeout and reset corner cases.
module tb_clock_set_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       mode_p, up_p, down_p;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [1:0] state;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic       load;
  logic       editing;

  int checks   = 0;
  int failures = 0;

  clock_set_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode_p   (mode_p),
    .up_p     (up_p),
    .down_p   (down_p),
    .cur_hour (cur_hour),
    .cur_min  (cur_min),
    .state    (state),
    .set_hour (set_hour),
    .set_min  (set_min),
    .load     (load),
    .editing  (editing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m, u, d;
    logic [4:0] ch;
    logic [5:0] cm;
    logic [1:0] st;
    logic [4:0] h;
    logic [5:0] mi;
    logic       ld;
    logic       ed;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [1:0] st, input logic [4:0] h,
                         input logic [5:0] mi, input logic ld, input logic ed);
    chk({nm, ".state"}, 32'(state), 32'(st));
    chk({nm, ".set_hour"}, 32'(set_hour), 32'(h));
    chk({nm, ".set_min"}, 32'(set_min), 32'(mi));
    chk({nm, ".load"}, 32'(load), 32'(ld));
    chk({nm, ".editing"}, 32'(editing), 32'(ed));
  endtask

  // Drive one cycle of pulses, sample 1 time unit after the edge, then idle the pulses.
  task automatic cyc(input logic m, input logic u, input logic d);
    mode_p = m; up_p = u; down_p = d;
    @(posedge clk);
    #1;
    mode_p = 1'b0; up_p = 1'b0; down_p = 1'b0;
  endtask

  initial begin
    logic [4:0] eh;
    reset = 1'b1; mode_p = 1'b0; up_p = 1'b0; down_p = 1'b0;
    cur_hour = 5'd13; cur_min = 6'd45;
    @(posedge clk); @(posedge clk); #1;
    chk_all("reset", 2'd0, 5'd0, 6'd0, 1'b0, 1'b0);
    reset = 1'b0;

    //                  m  u  d  ch  cm   st h   mi  ld ed
    tbl.push_back(vec_t'{0, 1, 0, 13, 45, 0,  0,  0, 0, 0}); // up ignored in RUN
    tbl.push_back(vec_t'{1, 0, 0, 13, 45, 1, 13, 45, 0, 1}); // capture
    tbl.push_back(vec_t'{0, 0, 0, 13, 45, 1, 13, 45, 0, 1});
    tbl.push_back(vec_t'{0, 0, 1, 13, 45, 1, 12, 45, 0, 1});
    tbl.push_back(vec_t'{0, 0, 1, 13, 45, 1, 11, 45, 0, 1});
    tbl.push_back(vec_t'{0, 0, 1, 13, 45, 1, 10, 45, 0, 1});
    tbl.push_back(vec_t'{0, 1, 1, 13, 45, 1, 10, 45, 0, 1}); // up+down cancel
    tbl.push_back(vec_t'{1, 1, 0, 13, 45, 2, 10, 45, 0, 1}); // mode wins
    tbl.push_back(vec_t'{0, 1, 0, 13, 45, 2, 10, 46, 0, 1});
    tbl.push_back(vec_t'{0, 0, 1, 13, 45, 2, 10, 45, 0, 1});
    tbl.push_back(vec_t'{0, 0, 1, 13, 45, 2, 10, 44, 0, 1});
    tbl.push_back(vec_t'{0, 1, 1, 13, 45, 2, 10, 44, 0, 1});
    tbl.push_back(vec_t'{1, 0, 0, 13, 45, 0, 10, 44, 1, 0}); // commit
    tbl.push_back(vec_t'{0, 0, 0, 13, 45, 0, 10, 44, 0, 0});
    tbl.push_back(vec_t'{0, 1, 0, 23, 59, 0, 10, 44, 0, 0}); // RUN holds
    tbl.push_back(vec_t'{1, 0, 0, 23, 59, 1, 23, 59, 0, 1});
    tbl.push_back(vec_t'{0, 1, 0, 23, 59, 1,  0, 59, 0, 1}); // 23 -> 0
    tbl.push_back(vec_t'{0, 0, 1, 23, 59, 1, 23, 59, 0, 1}); // 0 -> 23
    tbl.push_back(vec_t'{0, 1, 0, 23, 59, 1,  0, 59, 0, 1});
    tbl.push_back(vec_t'{0, 0, 0, 23, 59, 1,  0, 59, 0, 1});
    tbl.push_back(vec_t'{0, 1, 0, 23, 59, 1,  1, 59, 0, 1});
    tbl.push_back(vec_t'{0, 0, 0, 23, 59, 1,  1, 59, 0, 1});
    tbl.push_back(vec_t'{0, 1, 0, 23, 59, 1,  2, 59, 0, 1});
    tbl.push_back(vec_t'{1, 0, 0, 23, 59, 2,  2, 59, 0, 1});
    tbl.push_back(vec_t'{0, 1, 0, 23, 59, 2,  2,  0, 0, 1}); // 59 -> 0
    tbl.push_back(vec_t'{0, 0, 1, 23, 59, 2,  2, 59, 0, 1}); // 0 -> 59
    tbl.push_back(vec_t'{0, 1, 0, 23, 59, 2,  2,  0, 0, 1});
    tbl.push_back(vec_t'{1, 0, 0, 23, 59, 0,  2,  0, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 23, 59, 0,  2,  0, 0, 0}); // load lasts one cycle
    tbl.push_back(vec_t'{1, 0, 0, 23, 59, 1, 23, 59, 0, 1});
    tbl.push_back(vec_t'{1, 0, 0, 23, 59, 2, 23, 59, 0, 1});
    tbl.push_back(vec_t'{1, 0, 0, 23, 59, 0, 23, 59, 1, 0});
    tbl.push_back(vec_t'{1, 0, 0,  5,  6, 1,  5,  6, 0, 1}); // re-enter right after load

    for (int i = 0; i < tbl.size(); i++) begin
      cur_hour = tbl[i].ch; cur_min = tbl[i].cm;
      cyc(tbl[i].m, tbl[i].u, tbl[i].d);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].h, tbl[i].mi, tbl[i].ld, tbl[i].ed);
    end

    // Timeout from SET_HOUR: leave the edit without loading.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk_all("to_run", 2'd0, 5'd5, 6'd6, 1'b1, 1'b0);
    cur_hour = 5'd8; cur_min = 6'd20;
    cyc(1'b1, 1'b0, 1'b0);
    chk_all("to_enter", 2'd1, 5'd8, 6'd20, 1'b0, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk($sformatf("to_idle%0d.state", k), 32'(state), 32'd1);
      chk($sformatf("to_idle%0d.load", k), 32'(load), 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk_all("to_expire", 2'd0, 5'd8, 6'd20, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_all("to_after", 2'd0, 5'd8, 6'd20, 1'b0, 1'b0);

    // Press at idle cycle 10 restarts the window.
    cyc(1'b1, 1'b0, 1'b0);
    eh = 5'd8;
    for (int k = 1; k <= 9; k++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    eh = 5'd9;
    chk_all("to_press", 2'd1, eh, 6'd20, 1'b0, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk($sformatf("to_hold%0d.state", k), 32'(state), 32'd1);
      chk($sformatf("to_hold%0d.load", k), 32'(load), 32'd0);
    end
    // Press coinciding with the expiry cycle wins and restarts the count.
    cyc(1'b0, 1'b1, 1'b0);
    eh = 5'd10;
    chk_all("to_coinc", 2'd1, eh, 6'd20, 1'b0, 1'b1);
    for (int k = 1; k <= 15; k++) cyc(1'b0, 1'b0, 1'b0);
    chk("to_coinc_hold.state", 32'(state), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    chk_all("to_coinc_expire", 2'd0, eh, 6'd20, 1'b0, 1'b0);

    // Reset mid-edit in SET_MIN with a mode press pending: no load, values cleared.
    cur_hour = 5'd7; cur_min = 6'd30;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk_all("rst_pre", 2'd2, 5'd7, 6'd30, 1'b0, 1'b1);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    chk_all("rst_mid", 2'd0, 5'd0, 6'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rst_after.load", 32'(load), 32'd0);

    // Out-of-range live time is clamped to zero on capture.
    cur_hour = 5'd25; cur_min = 6'd61;
    cyc(1'b1, 1'b0, 1'b0);
    chk_all("clamp", 2'd1, 5'd0, 6'd0, 1'b0, 1'b1);
    cur_hour = 5'd31; cur_min = 6'd63;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk_all("clamp_max", 2'd1, 5'd0, 6'd0, 1'b0, 1'b1);
    cur_hour = 5'd24; cur_min = 6'd60;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk_all("clamp_edge", 2'd1, 5'd0, 6'd0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Independent guard: load must never be high two cycles running.
  logic load_q = 1'b0;
  always @(negedge clk) begin
    if (load && load_q) begin
      failures++;
      $display("FAIL load_consecutive actual=1 required=0");
    end
    load_q <= load;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
